// File: rtl/counter_ctrl_if.sv
// Control/status bundle between host logic, counter_ctrl and the counter datapath.
// The prescale field exists only when PRESCALE_EN is defined.
interface counter_ctrl_if #(
    parameter int W = 8
`ifdef PRESCALE_EN
    , parameter int PRESC_W = 4
`endif
);
    logic         start;
    logic         stop;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] term;
    logic         auto_reload;
    logic [W-1:0] count;
`ifdef PRESCALE_EN
    logic [PRESC_W-1:0] prescale;
`endif
    logic         cnt_en;
    logic         cnt_clr;
    logic         cnt_load;
    logic [W-1:0] cnt_load_val;
    logic         busy;
    logic         done;

    modport master (
        output start, stop, load, load_val, term, auto_reload, count,
`ifdef PRESCALE_EN
        output prescale,
`endif
        input  cnt_en, cnt_clr, cnt_load, cnt_load_val, busy, done
    );

    modport slave (
        input  start, stop, load, load_val, term, auto_reload, count,
`ifdef PRESCALE_EN
        input  prescale,
`endif
        output cnt_en, cnt_clr, cnt_load, cnt_load_val, busy, done
    );
endinterface

// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencing controller for a W-bit up-counter (clear, gate,
// preload, stop at terminal count, single-shot or auto-reload).
// Optional feature macro: PRESCALE_EN adds a PRESC_W-bit RUN-cycle divider
// that gates cnt_en to one cycle in every prescale+1.
module counter_ctrl #(
    parameter int W = 8
`ifdef PRESCALE_EN
    , parameter int PRESC_W = 4
`endif
) (
    input logic           clk,
    input logic           reset,
    counter_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic         load_q;
    logic [W-1:0] load_val_q;
    logic         at_term;
    logic         tick;

    assign at_term          = (bus.count == bus.term);
    assign bus.cnt_load     = load_q;
    assign bus.cnt_load_val = load_val_q;

    // State register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Preload strobe and registered value, accepted only in IDLE or PAUSE
    always_ff @(posedge clk) begin
        if (!reset) begin
            load_q     <= 1'b0;
            load_val_q <= '0;
        end else if (bus.load && (state == IDLE || state == PAUSE)) begin
            load_q     <= 1'b1;
            load_val_q <= bus.load_val;
        end else begin
            load_q     <= 1'b0;
        end
    end

`ifdef PRESCALE_EN
    logic [PRESC_W-1:0] psc;

    // Divider: cleared in CLR, advances in RUN only, holds elsewhere
    always_ff @(posedge clk) begin
        if (!reset)              psc <= '0;
        else if (state == CLR)   psc <= '0;
        else if (state == RUN)   psc <= (psc == bus.prescale) ? '0 : psc + PRESC_W'(1);
    end

    // Tick on phase zero so the first RUN cycle already counts
    assign tick = (psc == '0);
`else
    assign tick = 1'b1;
`endif

    // Next-state and Moore outputs; cnt_en also depends on count/term
    always_comb begin
        state_nx    = state;
        bus.cnt_en  = 1'b0;
        bus.cnt_clr = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.stop && bus.start) state_nx = CLR;
            end
            CLR: begin
                bus.cnt_clr = 1'b1;
                bus.busy    = 1'b1;
                state_nx    = RUN;
            end
            RUN: begin
                bus.busy   = 1'b1;
                bus.cnt_en = !at_term && tick;
                if (bus.stop)    state_nx = PAUSE;
                else if (at_term) state_nx = DONE;
            end
            PAUSE: begin
                bus.busy = 1'b1;
                if (bus.stop)       state_nx = IDLE;
                else if (bus.start) state_nx = RUN;
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = bus.auto_reload ? CLR : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl with a behavioural counter model and a
// done-event scoreboard (expected cycle/count pushed at stimulus time).
module tb_counter_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    counter_ctrl_if #(.W(8)) bus ();

    counter_ctrl #(.W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cycle index, advances on each active edge
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural counter driven by the controller outputs
    logic [7:0] cnt_q = '0;
    assign bus.count = cnt_q;
    always @(posedge clk) begin
        if (bus.cnt_clr)       cnt_q <= '0;
        else if (bus.cnt_load) cnt_q <= bus.cnt_load_val;
        else if (bus.cnt_en)   cnt_q <= cnt_q + 8'd1;
    end

    // Observed done pulses: cycle index and counter value
    int         obs_cyc[$];
    logic [7:0] obs_cnt[$];
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            obs_cyc.push_back(cyc);
            obs_cnt.push_back(cnt_q);
        end
    end

    int         exp_cyc[$];
    logic [7:0] exp_cnt[$];
    int         obs_rd = 0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [7:0] ck;
        reset = 1'b0;
        step(); step(); step();
        checks++;
        if ({bus.busy, bus.cnt_en, bus.cnt_clr, bus.cnt_load, bus.done} !== 5'b0 || bus.cnt_load_val !== 8'h00) begin
            errors++;
            $display("FAIL rst_outputs: got busy/en/clr/load/done=%b val=%h expected 00000 val=00",
                     {bus.busy, bus.cnt_en, bus.cnt_clr, bus.cnt_load, bus.done}, bus.cnt_load_val);
        end
        reset = 1'b1;
        step();
        bus.term = 8'd50;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (6) step();
        ck = cnt_q;
        reset = 1'b0;
        step();
        checks++;
        if ({bus.busy, bus.cnt_en, bus.cnt_clr, bus.cnt_load, bus.done} !== 5'b0) begin
            errors++;
            $display("FAIL rst_midrun_outputs: got %b expected 00000",
                     {bus.busy, bus.cnt_en, bus.cnt_clr, bus.cnt_load, bus.done});
        end
        checks++;
        if (cnt_q !== ck + 8'd1) begin
            errors++;
            $display("FAIL rst_midrun_count: got %h expected %h", cnt_q, ck + 8'd1);
        end
        step();
        checks++;
        if (cnt_q !== ck + 8'd1 || bus.busy !== 1'b0 || bus.cnt_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_frozen: got count=%h busy=%b en=%b expected count=%h busy=0 en=0",
                     cnt_q, bus.busy, bus.cnt_en, ck + 8'd1);
        end
        reset = 1'b1;
        step();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_release_idle: got busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic drain(input string tag);
        int         e_c;
        logic [7:0] e_n;
        while (exp_cyc.size() != 0) begin
            e_c = exp_cyc.pop_front();
            e_n = exp_cnt.pop_front();
            checks++;
            if (obs_rd >= obs_cyc.size()) begin
                errors++;
                $display("FAIL %s_done_missing: got none expected cycle %0d", tag, e_c);
            end else begin
                if (obs_cyc[obs_rd] !== e_c || obs_cnt[obs_rd] !== e_n) begin
                    errors++;
                    $display("FAIL %s_done: got cycle %0d count %h expected cycle %0d count %h",
                             tag, obs_cyc[obs_rd], obs_cnt[obs_rd], e_c, e_n);
                end
                obs_rd++;
            end
        end
        checks++;
        if (obs_rd != obs_cyc.size()) begin
            errors++;
            $display("FAIL %s_done_extra: got %0d pulses expected 0", tag, obs_cyc.size() - obs_rd);
            obs_rd = obs_cyc.size();
        end
    endtask

    task automatic test_single_shot;
        int   n;
        logic e_clr, e_en, e_busy;
        bus.term = 8'd5;
        bus.auto_reload = 1'b0;
        n = cyc;
        exp_cyc.push_back(n + 8);
        exp_cnt.push_back(8'd5);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            e_clr  = (k == 1);
            e_en   = (k >= 2 && k <= 6);
            e_busy = (k >= 1 && k <= 7);
            checks++;
            if (bus.cnt_clr !== e_clr || bus.cnt_en !== e_en || bus.busy !== e_busy) begin
                errors++;
                $display("FAIL ss_cycle%0d: got clr/en/busy=%b%b%b expected %b%b%b",
                         k, bus.cnt_clr, bus.cnt_en, bus.busy, e_clr, e_en, e_busy);
            end
            step();
        end
        checks++;
        if (cnt_q !== 8'd5) begin
            errors++;
            $display("FAIL ss_final_count: got %h expected 05", cnt_q);
        end
        drain("ss");
    endtask

    task automatic test_pause_resume;
        int r;
        bit found = 0;
        bus.term = 8'd5;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (cnt_q == 8'd2 && bus.cnt_en === 1'b1) begin
                found = 1;
                break;
            end
            step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL pr_reach2: got timeout expected count 02 while running");
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (cnt_q !== 8'd3 || bus.cnt_en !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL pr_hold%0d: got count=%h en=%b busy=%b expected 03 0 1",
                         k, cnt_q, bus.cnt_en, bus.busy);
            end
            step();
        end
        r = cyc;
        exp_cyc.push_back(r + 4);
        exp_cnt.push_back(8'd5);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (bus.cnt_clr !== 1'b0) begin
                errors++;
                $display("FAIL pr_no_clr%0d: got clr=%b expected 0", k, bus.cnt_clr);
            end
            step();
        end
        checks++;
        if (cnt_q !== 8'd5) begin
            errors++;
            $display("FAIL pr_final_count: got %h expected 05", cnt_q);
        end
        drain("pr");
    endtask

    task automatic test_auto_reload;
        int n;
        bus.term = 8'd2;
        bus.auto_reload = 1'b1;
        n = cyc;
        for (int k = 1; k <= 4; k++) begin
            exp_cyc.push_back(n + 5 * k);
            exp_cnt.push_back(8'd2);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        while (cyc < n + 16) step();
        bus.auto_reload = 1'b0;
        while (cyc < n + 21) step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL ar_idle%0d: got busy=%b expected 0", k, bus.busy);
            end
            step();
        end
        drain("ar");
    endtask

    task automatic test_term_zero;
        int n;
        bus.term = 8'd0;
        n = cyc;
        exp_cyc.push_back(n + 3);
        exp_cnt.push_back(8'd0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        checks++;
        if (bus.cnt_en !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL tz_run: got en=%b busy=%b expected 0 1", bus.cnt_en, bus.busy);
        end
        repeat (3) step();
        drain("tz");
    endtask

    task automatic test_load_wrap;
        int         p;
        logic [7:0] seq [4];
        seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        bus.term = 8'd1;
        bus.load = 1'b1;
        bus.load_val = 8'hFE;
        step();
        bus.load = 1'b0;
        checks++;
        if (bus.cnt_load !== 1'b1 || bus.cnt_load_val !== 8'hFE) begin
            errors++;
            $display("FAIL lw_idle_load: got load=%b val=%h expected 1 fe", bus.cnt_load, bus.cnt_load_val);
        end
        step();
        checks++;
        if (bus.cnt_load !== 1'b0 || cnt_q !== 8'hFE) begin
            errors++;
            $display("FAIL lw_loaded: got load=%b count=%h expected 0 fe", bus.cnt_load, cnt_q);
        end
        bus.start = 1'b1;
        bus.stop = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bus.busy !== 1'b0 || bus.cnt_clr !== 1'b0) begin
                errors++;
                $display("FAIL lw_start_stop%0d: got busy=%b clr=%b expected 0 0", k, bus.busy, bus.cnt_clr);
            end
            step();
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.cnt_en !== 1'b0 || cnt_q !== 8'd1) begin
            errors++;
            $display("FAIL lw_paused: got busy=%b en=%b count=%h expected 1 0 01", bus.busy, bus.cnt_en, cnt_q);
        end
        bus.load = 1'b1;
        bus.load_val = 8'hFE;
        step();
        bus.load = 1'b0;
        checks++;
        if (bus.cnt_load !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL lw_pause_load: got load=%b busy=%b expected 1 1", bus.cnt_load, bus.busy);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        p = cyc;
        exp_cyc.push_back(p + 4);
        exp_cnt.push_back(8'd1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cnt_q !== seq[k] || bus.cnt_clr !== 1'b0) begin
                errors++;
                $display("FAIL lw_wrap%0d: got count=%h clr=%b expected %h 0", k, cnt_q, bus.cnt_clr, seq[k]);
            end
            step();
        end
        repeat (2) step();
        drain("lw");
    endtask

`ifdef PRESCALE_EN
    task automatic test_prescale;
        int   n;
        logic e_en;
        bus.term = 8'd3;
        bus.prescale = 4'd1;
        n = cyc;
        exp_cyc.push_back(n + 8);
        exp_cnt.push_back(8'd3);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        for (int k = 0; k < 6; k++) begin
            e_en = (k % 2 == 0);
            checks++;
            if (bus.cnt_en !== e_en) begin
                errors++;
                $display("FAIL ps_en%0d: got %b expected %b", k, bus.cnt_en, e_en);
            end
            step();
        end
        checks++;
        if (cnt_q !== 8'd3) begin
            errors++;
            $display("FAIL ps_count: got %h expected 03", cnt_q);
        end
        repeat (2) step();
        drain("ps");
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.load = 1'b0;
        bus.load_val = '0;
        bus.term = '0;
        bus.auto_reload = 1'b0;
`ifdef PRESCALE_EN
        bus.prescale = '0;
`endif
        test_reset();
        test_single_shot();
        test_pause_resume();
        test_auto_reload();
        test_term_zero();
        test_load_wrap();
`ifdef PRESCALE_EN
        test_prescale();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
